// File: rtl/nobl_sram_responder_pkg.sv
// Shared constants for the NOBL SRAM pin interface: pipeline latencies, byte-lane width and
// the we-encoded operation type. Used by the responder, the arbiter and the bench.
package nobl_sram_responder_pkg;

    localparam int NOBL_RD_LAT = 2;
    localparam int NOBL_WR_LAT = 2;
    localparam int NOBL_LANE_W = 9;

    // Encoding follows the active-low sram_we pin directly.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } nobl_op_e;

endpackage

// File: rtl/nobl_sram_responder_if.sv
// SRAM pin bundle between the arbiter (master) and an SRAM part or its on-chip emulation (slave).
interface nobl_sram_responder_if #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 36
);
    import nobl_sram_responder_pkg::*;

    localparam int LANES = SRAM_DATA_WIDTH / NOBL_LANE_W;

    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic                       sram_we;
    logic [LANES-1:0]           sram_bw;
    logic [SRAM_DATA_WIDTH-1:0] sram_wr_data;
    logic                       sram_tri_en;
    logic [SRAM_DATA_WIDTH-1:0] sram_rd_data;
    logic                       sram_rd_drive;

    modport master (
        output sram_addr, sram_we, sram_bw, sram_wr_data, sram_tri_en,
        input  sram_rd_data, sram_rd_drive
    );

    modport slave (
        input  sram_addr, sram_we, sram_bw, sram_wr_data, sram_tri_en,
        output sram_rd_data, sram_rd_drive
    );

endinterface

// File: rtl/nobl_sram_responder_mem.sv
// Simple dual-port RAM with per-lane write enables and a registered read port; read-first on
// an address collision so the responder's forwarding logic sees the pre-write word.
module nobl_sram_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36,
    parameter int LANE_WIDTH = 9,
    parameter int LANES      = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic [LANES-1:0]      wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

    // Storage is never reset so committed data survives a responder reset.
    always_ff @(posedge clk) begin
        rd_data <= mem_r[rd_addr];
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem_r[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/nobl_sram_responder.sv
// On-chip emulation of a 2-clock-latency NOBL SRAM: control pipeline, write commit, read
// forwarding of the two most recent writes, bus-turnaround checker and write counter.
module nobl_sram_responder
    import nobl_sram_responder_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 36,
    parameter int MEM_ADDR_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    nobl_sram_responder_if.slave         bus,
    input  logic                         err_clr,
    output logic                         err_tri,
    output logic                         err_contend,
    output logic [31:0]                  wr_count
);

    localparam int LANES = SRAM_DATA_WIDTH / NOBL_LANE_W;

    typedef logic [SRAM_DATA_WIDTH-1:0] word_t;
    typedef logic [MEM_ADDR_WIDTH-1:0]  maddr_t;

    // Lanes whose active-low enable is 0 take the update, the rest keep the base word.
    function automatic word_t lane_merge(input word_t base, input word_t upd,
                                         input logic [LANES-1:0] bw_n);
        word_t res;
        res = base;
        for (int i = 0; i < LANES; i++) begin
            res[i*NOBL_LANE_W +: NOBL_LANE_W] = bw_n[i] ? base[i*NOBL_LANE_W +: NOBL_LANE_W]
                                                        : upd[i*NOBL_LANE_W +: NOBL_LANE_W];
        end
        return res;
    endfunction

    logic             s1_valid_r, s2_valid_r, s3_valid_r;
    nobl_op_e         s1_op_r, s2_op_r;
    maddr_t           s1_addr_r, s2_addr_r, s3_addr_r;
    logic [LANES-1:0] s1_bw_r, s2_bw_r, s3_bw_r;
    word_t            s3_data_r;
    word_t            rd_data_r;
    logic             rd_drive_r;
    logic             err_tri_r, err_contend_r;
    logic [31:0]      wr_count_r;

    logic             s1_rd_s, s2_wr_s;
    logic             hit3_s, hit2_s;
    logic             tri_viol_s, contend_viol_s;
    word_t            mem_q_s, fwd3_s, fwd_word_s;
    logic [LANES-1:0] mem_wr_en_s;

    assign s1_rd_s = s1_valid_r && (s1_op_r == OP_READ);
    assign s2_wr_s = s2_valid_r && (s2_op_r == OP_WRITE);

    assign mem_wr_en_s = {LANES{s2_wr_s}} & ~s2_bw_r;

    nobl_sram_mem #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH),
        .DATA_WIDTH (SRAM_DATA_WIDTH),
        .LANE_WIDTH (NOBL_LANE_W),
        .LANES      (LANES)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en_s),
        .wr_addr (s2_addr_r),
        .wr_data (bus.sram_wr_data),
        .rd_addr (bus.sram_addr[MEM_ADDR_WIDTH-1:0]),
        .rd_data (mem_q_s)
    );

    // The RAM is read at the end of cycle A. In A+1 the write from A-2 (committed in the same
    // edge, read-first) sits in stage 3 and the write from A-1 is in stage 2 with its data on
    // the bus; applying them oldest first gives newest-wins per lane.
    assign hit3_s     = s3_valid_r && (s3_addr_r == s1_addr_r);
    assign hit2_s     = s2_wr_s && (s2_addr_r == s1_addr_r);
    assign fwd3_s     = hit3_s ? lane_merge(mem_q_s, s3_data_r, s3_bw_r) : mem_q_s;
    assign fwd_word_s = hit2_s ? lane_merge(fwd3_s, bus.sram_wr_data, s2_bw_r) : fwd3_s;

    // Checks only start once stage 2 holds a real post-reset operation.
    assign tri_viol_s     = s2_valid_r && (bus.sram_tri_en != s2_wr_s);
    assign contend_viol_s = s2_valid_r && bus.sram_tri_en && rd_drive_r;

    // Control pipeline, read data register, sticky error flags and committed-write counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r    <= 1'b0;
            s1_op_r       <= OP_READ;
            s1_addr_r     <= '0;
            s1_bw_r       <= '1;
            s2_valid_r    <= 1'b0;
            s2_op_r       <= OP_READ;
            s2_addr_r     <= '0;
            s2_bw_r       <= '1;
            s3_valid_r    <= 1'b0;
            s3_addr_r     <= '0;
            s3_bw_r       <= '1;
            s3_data_r     <= '0;
            rd_data_r     <= '0;
            rd_drive_r    <= 1'b0;
            err_tri_r     <= 1'b0;
            err_contend_r <= 1'b0;
            wr_count_r    <= 32'd0;
        end else begin
            s1_valid_r    <= 1'b1;
            s1_op_r       <= nobl_op_e'(bus.sram_we);
            s1_addr_r     <= bus.sram_addr[MEM_ADDR_WIDTH-1:0];
            s1_bw_r       <= bus.sram_bw;
            s2_valid_r    <= s1_valid_r;
            s2_op_r       <= s1_op_r;
            s2_addr_r     <= s1_addr_r;
            s2_bw_r       <= s1_bw_r;
            s3_valid_r    <= s2_wr_s;
            s3_addr_r     <= s2_addr_r;
            s3_bw_r       <= s2_bw_r;
            s3_data_r     <= bus.sram_wr_data;
            rd_drive_r    <= s1_rd_s;
            err_tri_r     <= tri_viol_s | (err_tri_r & ~err_clr);
            err_contend_r <= contend_viol_s | (err_contend_r & ~err_clr);
            if (s1_rd_s) begin
                rd_data_r <= fwd_word_s;
            end
            if (s2_wr_s) begin
                wr_count_r <= wr_count_r + 32'd1;
            end
        end
    end

    assign bus.sram_rd_data  = rd_data_r;
    assign bus.sram_rd_drive = rd_drive_r;
    assign err_tri           = err_tri_r;
    assign err_contend       = err_contend_r;
    assign wr_count          = wr_count_r;

endmodule
